fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fb_pkg.sv
// Framebuffer arbiter shared definitions.
// Display timing constants and the arbiter state encoding.
package fb_pkg;

    localparam int H_RES          = 640;
    localparam int H_TOTAL        = 800;
    localparam int V_RES          = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display line fetch has priority,
// the CPU is served only while the fetch engine is idle.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int ADDRW = 15,
    parameter int DATAW = 64
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             cpu_valid,
    input  logic             cpu_we,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [DATAW-1:0] cpu_wdata,
    output logic             cpu_ready,
    output logic             cpu_rvalid,
    output logic [DATAW-1:0] cpu_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    output logic             lb_we,
    output logic             lb_bank,
    output logic [5:0]       lb_addr,
    output logic [DATAW-1:0] lb_wdata,
    output logic             fetch_late
);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_word;
    logic [CORDW-1:0] r_row;
    logic             r_lb_we;
    logic             r_lb_bank;
    logic [5:0]       r_lb_addr;
    logic             r_rvalid;
    logic             r_late;

    logic             w_trig;
    logic             w_idle;
    logic             w_last;
    logic             w_cpu_go;
    logic [CORDW-1:0] w_row;
    logic [ADDRW-1:0] w_fetch_addr;

    assign w_trig = (sx == CORDW'(H_RES)) &&
                    ((sy < CORDW'(V_RES - 1)) ||
                     (sy == CORDW'(V_TOTAL - 1)));
    assign w_row  = (sy == CORDW'(V_TOTAL - 1)) ?
                    '0 : sy + CORDW'(1);
    assign w_idle = (r_state == ST_IDLE);
    assign w_last = (r_word == 6'(WORDS_PER_LINE - 1));

    // CPU is only granted while idle, not triggering and out of reset
    assign w_cpu_go = rst_pix_n && w_idle && !w_trig && cpu_valid;

    assign w_fetch_addr = ADDRW'(r_row) * ADDRW'(WORDS_PER_LINE) +
                          ADDRW'(r_word);

    // State register
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    // Next-state: trigger starts a fetch, last word drains, drain returns
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_trig) w_next = ST_FETCH;
            ST_FETCH: if (w_last) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // RAM port mux: fetch reads while fetching, otherwise granted CPU access
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ready = w_cpu_go;
        if (r_state == ST_FETCH) begin
            mem_en   = 1'b1;
            mem_addr = w_fetch_addr;
        end else if (w_cpu_go) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Word counter and latched row for the line being fetched
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_word <= '0;
            r_row  <= '0;
        end else if (w_idle && w_trig) begin
            r_word <= '0;
            r_row  <= w_row;
        end else if (r_state == ST_FETCH && !w_last) begin
            r_word <= r_word + 6'd1;
        end
    end

    // Read-return tagging: each RAM read lands one cycle later
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_lb_we   <= 1'b0;
            r_lb_bank <= 1'b0;
            r_lb_addr <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_lb_we   <= (r_state == ST_FETCH);
            r_lb_bank <= r_row[0];
            r_lb_addr <= r_word;
            r_rvalid  <= w_cpu_go && !cpu_we;
        end
    end

    // Sticky overrun flag: line start or new trigger while still busy
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n)
            r_late <= 1'b0;
        else if (!w_idle && (sx == '0 || w_trig))
            r_late <= 1'b1;
    end

    assign lb_we      = r_lb_we;
    assign lb_bank    = r_lb_bank;
    assign lb_addr    = r_lb_addr;
    assign lb_wdata   = r_lb_we ? mem_rdata : '0;
    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = r_rvalid ? mem_rdata : '0;
    assign fetch_late = r_late;

endmodule
